// File: rtl/rv_alu_issue.sv
// Decode-to-execute issue stage feeding the RV32I ALU: one-cycle latency from accept to out_valid_o.
// Backpressure: SKID=1 absorbs one extra entry behind a registered in_ready_o; SKID=0 stalls combinationally.
module rv_alu_issue #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [3:0]      op_sel_o,
    output logic            is_branch_o,
    output logic            br_inv_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("rv_alu_issue supports XLEN=32 only");
    end

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SLL = 4'b0010,
                           OP_SRL = 4'b0011, OP_SRA = 4'b0100, OP_OR  = 4'b0101,
                           OP_AND = 4'b0110, OP_XOR = 4'b0111, OP_EQL = 4'b1000,
                           OP_ULT = 4'b1001, OP_SLT = 4'b1011;

    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011,
                           OPC_LOAD   = 7'b0000011, OPC_STORE  = 7'b0100011,
                           OPC_JALR   = 7'b1100111, OPC_LUI    = 7'b0110111,
                           OPC_AUIPC  = 7'b0010111, OPC_JAL    = 7'b1101111,
                           OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [3:0]      op_sel;
        logic            is_branch;
        logic            br_inv;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && sub_ok) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_ULT;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {instr_i[31:12], 12'h000};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    entry_t dec;

    always_comb begin
        dec       = '0;
        dec.rd    = instr_i[11:7];
        dec.pc    = pc_i;
        case (opcode)
            OPC_OP: begin
                dec.opr_a  = rs1_data_i;
                dec.opr_b  = rs2_data_i;
                dec.op_sel = alu_op(funct3, instr_i[30], 1'b1);
            end
            OPC_OP_IMM: begin
                // instr[30] is part of the immediate here, so it only selects SRA, never SUB
                dec.opr_a  = rs1_data_i;
                dec.opr_b  = imm_i;
                dec.op_sel = alu_op(funct3, instr_i[30], 1'b0);
            end
            OPC_LOAD, OPC_JALR: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = imm_i;
            end
            OPC_STORE: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = imm_s;
            end
            OPC_LUI:   dec.opr_b = imm_u;
            OPC_AUIPC: begin
                dec.opr_a = pc_i;
                dec.opr_b = imm_u;
            end
            OPC_JAL: begin
                dec.opr_a = pc_i;
                dec.opr_b = imm_j;
            end
            OPC_BRANCH: begin
                dec.opr_a     = rs1_data_i;
                dec.opr_b     = rs2_data_i;
                dec.is_branch = 1'b1;
                dec.br_inv    = funct3[0];
                case (funct3)
                    3'b000, 3'b001: dec.op_sel = OP_EQL;
                    3'b100, 3'b101: dec.op_sel = OP_SLT;
                    3'b110, 3'b111: dec.op_sel = OP_ULT;
                    default: begin
                        dec.illegal   = 1'b1;
                        dec.is_branch = 1'b0;
                        dec.br_inv    = 1'b0;
                        dec.opr_a     = '0;
                        dec.opr_b     = '0;
                    end
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    logic   m_vld, s_vld;
    entry_t m_dat, s_dat;
    logic   accept, m_free;

    assign in_ready_o = (SKID != 0) ? !s_vld : (!m_vld || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign m_free     = !m_vld || out_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= '0;
            s_dat <= '0;
        end else if (flush_i) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (m_free) begin
            if (s_vld) begin
                // older skid entry advances first to keep FIFO order
                m_vld <= 1'b1;
                m_dat <= s_dat;
                s_vld <= accept;
                if (accept) s_dat <= dec;
            end else begin
                m_vld <= accept;
                if (accept) m_dat <= dec;
            end
        end else if ((SKID != 0) && accept) begin
            s_vld <= 1'b1;
            s_dat <= dec;
        end
    end

    assign out_valid_o = m_vld;
    assign opr_a_o     = m_dat.opr_a;
    assign opr_b_o     = m_dat.opr_b;
    assign op_sel_o    = m_dat.op_sel;
    assign is_branch_o = m_dat.is_branch;
    assign br_inv_o    = m_dat.br_inv;
    assign rd_o        = m_dat.rd;
    assign pc_o        = m_dat.pc;
    assign illegal_o   = m_dat.illegal;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed bench for rv_alu_issue (SKID=1): decode vectors, backpressure ordering, flush and async reset.
module tb_rv_alu_issue;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1, rs2, opr_a, opr_b, pc_out;
    logic [3:0]  op_sel;
    logic        is_branch, br_inv, illegal;
    logic [4:0]  rd;
    int          total = 0;
    int          bad   = 0;

    rv_alu_issue #(.XLEN(32), .SKID(1)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc),
        .rs1_data_i(rs1), .rs2_data_i(rs2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .opr_a_o(opr_a), .opr_b_o(opr_b), .op_sel_o(op_sel),
        .is_branch_o(is_branch), .br_inv_o(br_inv), .rd_o(rd), .pc_o(pc_out),
        .illegal_o(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1      = a;
        rs2      = b;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_op, input logic [31:0] e_a,
                           input logic [31:0] e_b, input logic e_br, input logic e_inv, input logic e_ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".op"},    32'(op_sel),    32'(e_op));
        chk({tag, ".a"},     opr_a,          e_a);
        chk({tag, ".b"},     opr_b,          e_b);
        chk({tag, ".br"},    32'(is_branch), 32'(e_br));
        chk({tag, ".inv"},   32'(br_inv),    32'(e_inv));
        chk({tag, ".ill"},   32'(illegal),   32'(e_ill));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1 = '0; rs2 = '0;
        #2;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(in_ready),  32'd1);
        chk("rst.a",     opr_a,          32'd0);
        chk("rst.op",    32'(op_sel),    32'd0);
        #1 reset = 1'b0;

        // ADD x3,x1,x2
        drive(32'h002081B3, 32'h40, 32'd5, 32'd7);
        tick();
        chk_out("add", 4'b0000, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("add.rd", 32'(rd), 32'd3);
        chk("add.pc", pc_out, 32'h40);

        // SRAI x1,x2,4 then SLLI back-to-back
        drive(32'h40415093, 32'h44, 32'h80000000, 32'd9);
        tick();
        chk_out("srai", 4'b0100, 32'h80000000, 32'h00000404, 1'b0, 1'b0, 1'b0);
        chk("srai.rd", 32'(rd), 32'd1);
        drive(32'h00411093, 32'h48, 32'h80000000, 32'd9);
        tick();
        chk_out("slli", 4'b0010, 32'h80000000, 32'h00000004, 1'b0, 1'b0, 1'b0);

        // BGEU x1,x2,+8 then AUIPC x5,0x12345
        drive(32'h0020F463, 32'h4C, 32'd1, 32'd2);
        tick();
        chk_out("bgeu", 4'b1001, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        chk("bgeu.rd", 32'(rd), 32'd8);
        drive(32'h12345297, 32'h100, 32'h77, 32'h88);
        tick();
        chk_out("auipc", 4'b0000, 32'h100, 32'h12345000, 1'b0, 1'b0, 1'b0);
        chk("auipc.rd", 32'(rd), 32'd5);

        // SUB, ADDI with instr[30] set, LUI, JAL -4, SW -8, illegal branch funct3
        drive(32'h40208133, 32'h104, 32'd20, 32'd3);
        tick();
        chk_out("sub", 4'b0001, 32'd20, 32'd3, 1'b0, 1'b0, 1'b0);
        drive(32'h40000093, 32'h108, 32'd6, 32'd0);
        tick();
        chk_out("addi30", 4'b0000, 32'd6, 32'h400, 1'b0, 1'b0, 1'b0);
        drive(32'hABCDE0B7, 32'h10C, 32'h55, 32'h66);
        tick();
        chk_out("lui", 4'b0000, 32'd0, 32'hABCDE000, 1'b0, 1'b0, 1'b0);
        drive(32'hFFDFF0EF, 32'h200, 32'h55, 32'h66);
        tick();
        chk_out("jal", 4'b0000, 32'h200, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
        drive(32'hFE20AC23, 32'h204, 32'h1000, 32'h66);
        tick();
        chk_out("sw", 4'b0000, 32'h1000, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0);
        chk("sw.rd", 32'(rd), 32'd24);
        drive(32'h0020A463, 32'h208, 32'd1, 32'd2);
        tick();
        chk_out("brill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Backpressure: three back-to-back with out_ready low
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h300, 32'd1, 32'd10);
        chk("bp.rdy0", 32'(in_ready), 32'd1);
        tick();
        chk("bp.rdy1", 32'(in_ready), 32'd1);
        drive(32'h002081B3, 32'h304, 32'd2, 32'd10);
        tick();
        chk("bp.rdy2", 32'(in_ready), 32'd0);
        chk("bp.hold1", opr_a, 32'd1);
        drive(32'h002081B3, 32'h308, 32'd3, 32'd10);
        tick();
        chk("bp.stall", opr_a, 32'd1);
        chk("bp.rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp.out2.v", 32'(out_valid), 32'd1);
        chk("bp.out2", opr_a, 32'd2);
        chk("bp.rdy4", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp.out3.v", 32'(out_valid), 32'd1);
        chk("bp.out3", opr_a, 32'd3);
        chk("bp.out3.pc", pc_out, 32'h308);
        tick();
        chk("bp.empty", 32'(out_valid), 32'd0);

        // Illegal opcode still handshakes
        out_ready = 1'b0;
        drive(32'h0000007F, 32'h400, 32'hDEAD, 32'hBEEF);
        tick();
        in_valid = 1'b0;
        chk_out("ill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("ill.gone", 32'(out_valid), 32'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h500, 32'h11, 32'd0);
        tick();
        drive(32'h002081B3, 32'h504, 32'h22, 32'd0);
        tick();
        chk("fl.full", 32'(in_ready), 32'd0);
        drive(32'h002081B3, 32'h508, 32'h33, 32'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready),  32'd1);
        tick();
        chk("fl.nodup", 32'(out_valid), 32'd0);

        // Flush with only M full: the same-cycle accepted input is discarded
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h600, 32'h44, 32'd0);
        tick();
        drive(32'h002081B3, 32'h604, 32'h55, 32'd0);
        chk("fl2.rdy", 32'(in_ready), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl2.valid", 32'(out_valid), 32'd0);
        tick();
        chk("fl2.drop", 32'(out_valid), 32'd0);

        // Async reset mid-stall, then accept on the first edge after release
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h700, 32'h66, 32'd1);
        tick();
        drive(32'h002081B3, 32'h704, 32'h77, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rs.full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rs.valid", 32'(out_valid), 32'd0);
        chk("rs.ready", 32'(in_ready),  32'd1);
        chk("rs.a",     opr_a,          32'd0);
        chk("rs.b",     opr_b,          32'd0);
        chk("rs.pc",    pc_out,         32'd0);
        chk("rs.rd",    32'(rd),        32'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h800, 32'd9, 32'd4);
        tick();
        in_valid = 1'b0;
        chk_out("rs.first", 4'b0000, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0);
        chk("rs.first.pc", pc_out, 32'h800);
        tick();
        chk("rs.end", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_alu_issue.md
Name: rv_alu_issue

Overview:
Decode-to-execute issue stage that sits directly upstream of the RV32I ALU. It takes a fetched instruction, its PC and the register-file read data, and decodes them into the ALU's op_sel code and its two operands. The result is held in an output register behind a valid/ready handshake, with an optional skid entry. Its outputs drive the ALU operand and op-select inputs one cycle after the instruction is accepted.

Parameters:
XLEN, 32, datapath width; only 32 is supported (elaboration error otherwise).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register, combinational in_ready_o = !out_valid_o || out_ready_i.

Ports:
clk_i  input  1  clock, rising edge.
reset_i  input  1  asynchronous, active-high reset.
flush_i  input  1  synchronous kill of all held entries.
in_valid_i  input  1  upstream instruction valid.
in_ready_o  output  1  stage can accept an instruction.
instr_i  input  32  raw instruction.
pc_i  input  32  instruction PC.
rs1_data_i  input  32  rs1 read data.
rs2_data_i  input  32  rs2 read data.
out_valid_o  output  1  issued entry valid.
out_ready_i  input  1  downstream accepts the entry.
opr_a_o  output  32  ALU operand A.
opr_b_o  output  32  ALU operand B.
op_sel_o  output  4  ALU op select.
is_branch_o  output  1  entry is a conditional branch.
br_inv_o  output  1  invert the ALU 1-bit result for the branch decision.
rd_o  output  5  destination register, instr[11:7].
pc_o  output  32  PC of the entry.
illegal_o  output  1  unsupported opcode.

Behaviour:
- op_sel encoding: ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, OR 0101, AND 0110, XOR 0111, EQL 1000, ULT 1001, UGT 1010, SLT 1011, SGE 1100.
- Immediates are sign-extended to 32 bits:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - U = {instr[31:12], 12'h0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
- OP (0110011): A=rs1, B=rs2. funct3 mapping:
  - 000 ADD, or SUB if instr[30]
  - 001 SLL, 010 SLT, 011 ULT, 100 XOR
  - 101 SRL, or SRA if instr[30]
  - 110 OR, 111 AND
- OP-IMM (0010011): A=rs1, B=I-imm. Same mapping as OP, except 000 is always ADD. For shifts, B[4:0] = shamt.
- Address and link computations, all op_sel=ADD:
  - LOAD (0000011): A=rs1, B=I-imm.
  - STORE (0100011): A=rs1, B=S-imm.
  - JALR (1100111): A=rs1, B=I-imm.
  - LUI (0110111): A=0, B=U-imm.
  - AUIPC (0010111): A=pc, B=U-imm.
  - JAL (1101111): A=pc, B=J-imm.
- BRANCH (1100011): A=rs1, B=rs2, is_branch=1. funct3 mapping:
  - 000 EQL, inv=0; 001 EQL, inv=1
  - 100 SLT, inv=0; 101 SLT, inv=1
  - 110 ULT, inv=0; 111 ULT, inv=1
  - 010/011: illegal.
- Any other opcode, or an illegal branch funct3: illegal=1, op_sel=ADD, A=B=0, is_branch=0, br_inv=0. The entry still flows through the handshake.
- pc_o and rd_o pass through unchanged. br_inv_o=0 for all non-branches.
- Latency: accept at edge N, so out_valid_o=1 with the decoded fields after edge N. Throughput is 1 per cycle while out_ready_i=1.
- Handshake:
  - Transfer on valid&&ready.
  - out_* are stable while out_valid_o=1 and out_ready_i=0.
  - in_valid_i may drop without a transfer.
- SKID=1 storage: main entry M drives the outputs; skid entry S holds overflow.
  - in_ready_o = !S.valid (registered).
  - If M is empty or M transfers this cycle: M takes S if S is valid, otherwise the accepted input. If S moved to M, the accepted input goes to S.
  - If M is held (valid and not consumed): the accepted input goes to S.
  - Strict FIFO order; no entry is ever dropped or duplicated.
- Simultaneous accept and transfer with both entries empty-after-transfer: the new entry lands in M, out_valid_o stays 1.
- flush_i=1: M.valid and S.valid clear at the edge. A same-cycle input transfer is discarded, and so is a same-cycle output transfer (downstream must ignore it). in_ready_o=1 the next cycle.
- reset_i asserted (any time, including mid-stall):
  - all valids 0, all data outputs 0, in_ready_o=1 (SKID=1).
  - Outputs reach these values immediately, without waiting for a clock edge.
  - The first accept is possible on the first edge after deassertion.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op_sel=0000, A=5, B=7, rd=3, illegal=0.
2. SRAI x1,x2,4 (0x40415093), rs1=0x80000000 -> op_sel=0100, A=0x80000000, B[4:0]=4, B=0x00000404 (I-imm with instr[30]). SLLI (0x00411093) -> op_sel=0010.
3. BGEU x1,x2,+8 (0x0020F463) -> op_sel=1001, br_inv=1, is_branch=1. AUIPC x5,0x12345 (0x12345297) at pc=0x100 -> A=0x100, B=0x12345000, op_sel=0000.
4. Backpressure: hold out_ready=0, send 3 back-to-back instructions -> first two are accepted, in_ready=0 after the second. Release out_ready -> outputs appear in order 1,2,3 on consecutive cycles with no bubble, and nothing is lost.
5. Illegal opcode 0x0000007F -> illegal=1, A=B=0, op_sel=0000, entry still handshakes.
6. Both entries full, then flush_i=1 for one cycle with in_valid=1 -> out_valid=0 and in_ready=1 next cycle, and the flushed-cycle input is not issued. Repeat with reset_i asserted mid-stall -> out_valid=0 and outputs zero immediately.
